// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch datapath: FSM state encoding,
// default timing constants and a counter-width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam int CLK_HZ_DEFAULT     = 50_000_000;
  localparam int TICK_HZ_DEFAULT    = 1;
  localparam int DEB_CYCLES_DEFAULT = 1_000_000;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchroniser, level debouncer and a
// single-cycle press pulse on each accepted rising level.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int              CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has persisted for DEB_CYCLES cycles;
  // any bounce back to the current level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_b != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Registered rising-edge detect; releases produce nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/stopwatch_tick_ctrl.sv
// Run/pause/clear control for the minute counter: debounced buttons drive
// a small FSM that gates a seconds prescaler and issues counter clears.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | stopped and cleared, prescaler forced to 0
//   ST_RUN   | prescaler counting, tick_sec once per DIV cycles
//   ST_PAUSE | prescaler frozen so resume keeps the fractional second
//   2'b11    | unreachable; recovers to ST_IDLE without pulses
module stopwatch_tick_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int TICK_HZ    = TICK_HZ_DEFAULT,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic       tick_sec,
  output logic       clear_cnt,
  output logic       running,
  output logic [1:0] state
);

  localparam int            DIV        = CLK_HZ / TICK_HZ;
  localparam int            PW         = cnt_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t        st;
  logic [PW-1:0] presc;
  logic          ss_press;
  logic          clr_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start_stop),
    .press (ss_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .press (clr_press)
  );

  // FSM, prescaler and registered pulse outputs; clear always beats start/stop
  // and suppresses any tick that would land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= ST_IDLE;
      presc     <= '0;
      tick_sec  <= 1'b0;
      clear_cnt <= 1'b0;
    end else begin
      tick_sec  <= 1'b0;
      clear_cnt <= 1'b0;
      case (st)
        ST_IDLE: begin
          presc <= '0;
          if (clr_press) begin
            st        <= ST_IDLE;
            clear_cnt <= 1'b1;
          end else if (ss_press) begin
            st <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (presc == PRESC_LAST) begin
            presc    <= '0;
            tick_sec <= ~clr_press;
          end else begin
            presc <= presc + 1'b1;
          end
          if (clr_press) begin
            st        <= ST_IDLE;
            presc     <= '0;
            clear_cnt <= 1'b1;
          end else if (ss_press) begin
            st <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (clr_press) begin
            st        <= ST_IDLE;
            presc     <= '0;
            clear_cnt <= 1'b1;
          end else if (ss_press) begin
            st <= ST_RUN;
          end
        end
        default: begin
          st    <= ST_IDLE;
          presc <= '0;
        end
      endcase
    end
  end

  // Status decodes straight off the state register.
  always_comb begin
    running = (st == ST_RUN);
    state   = st;
  end

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_stopwatch_tick_ctrl;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DEB     = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int HW      = DEB + 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       b_ss  = 1'b0;
  logic       b_clr = 1'b0;
  logic       tick_sec;
  logic       clear_cnt;
  logic       running;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  stopwatch_tick_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .DEB_CYCLES (DEB)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (b_ss),
    .btn_clear      (b_clr),
    .tick_sec       (tick_sec),
    .clear_cnt      (clear_cnt),
    .running        (running),
    .state          (state)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. h_* keeps raw samples (index k = k edges ago). The
  // synchronised value lags raw by two edges, so a new debounced level is
  // accepted once raw samples 2..DEB+1 edges old all disagree with it.
  logic [HW-1:0] h_ss  = '0;
  logic [HW-1:0] h_clr = '0;
  logic d_ss = 1'b0, dp_ss = 1'b0, p_ss = 1'b0;
  logic d_clr = 1'b0, dp_clr = 1'b0, p_clr = 1'b0;
  logic [1:0] m_state = 2'd0;
  int         m_presc = 0;
  logic       m_tick  = 1'b0;
  logic       m_clr   = 1'b0;

  // Returns {debounced level now, level one edge ago, press pulse now}.
  function automatic logic [2:0] btn_model(input logic [HW-1:0] h, input logic d,
                                           input logic dp);
    logic [HW-3:0] win;
    logic          flip;
    win  = h[HW-1:2];
    flip = d ? (win == '0) : (&win);
    return {flip ? ~d : d, d, d & ~dp};
  endfunction

  always @(posedge clk) begin
    logic ss, cl, was_run;
    if (!rst) begin
      h_ss = '0; h_clr = '0;
      d_ss = 1'b0; dp_ss = 1'b0; p_ss = 1'b0;
      d_clr = 1'b0; dp_clr = 1'b0; p_clr = 1'b0;
      m_state = 2'd0; m_presc = 0; m_tick = 1'b0; m_clr = 1'b0;
    end else begin
      ss = p_ss;
      cl = p_clr;
      h_ss  = {h_ss[HW-2:0], b_ss};
      h_clr = {h_clr[HW-2:0], b_clr};
      {d_ss, dp_ss, p_ss}    = btn_model(h_ss, d_ss, dp_ss);
      {d_clr, dp_clr, p_clr} = btn_model(h_clr, d_clr, dp_clr);
      was_run = (m_state == 2'd1);
      m_tick  = was_run && (m_presc == DIV - 1) && !cl;
      m_clr   = cl;
      if (m_state != 2'd2) m_presc = was_run ? (m_presc + 1) % DIV : 0;
      if (cl) begin
        m_state = 2'd0;
        m_presc = 0;
      end else if (ss) begin
        m_state = (m_state == 2'd1) ? 2'd2 : 2'd1;
      end
    end
    chk_en = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("tick_sec", tick_sec, m_tick);
      chk1("clear_cnt", clear_cnt, m_clr);
      chk2("state", state, m_state);
      chk1("running", running, m_state == 2'd1);
    end
  end

  initial begin
    // Reset with both buttons held high.
    rst = 1'b0; b_ss = 1'b1; b_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk2("rst_state", state, 2'd0);
      chk1("rst_tick", tick_sec, 1'b0);
      chk1("rst_clear", clear_cnt, 1'b0);
      chk1("rst_running", running, 1'b0);
    end
    rst = 1'b1; b_ss = 1'b0; b_clr = 1'b0;
    repeat (4) @(negedge clk);

    // Start: RUN on the 8th edge after the raw rise, ticks every 10 cycles.
    b_ss = 1'b1;
    repeat (7) @(negedge clk);
    chk2("start_pre", state, 2'd0);
    @(negedge clk);
    chk2("start_run", state, 2'd1);
    chk2("model_start", m_state, 2'd1);
    b_ss = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk1("tick_run", tick_sec, (k % 10) == 0);
      if (k == 10) chk1("model_tick", m_tick, 1'b1);
    end

    // Pause three cycles after the tick at +40.
    repeat (5) @(negedge clk);
    b_ss = 1'b1;
    repeat (7) @(negedge clk);
    chk2("pause_pre", state, 2'd1);
    @(negedge clk);
    chk2("pause_state", state, 2'd2);
    b_ss = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk1("pause_no_tick", tick_sec, 1'b0);
    end

    // Bouncy resume: only the final stable rise counts.
    for (int i = 0; i < 4; i++) begin
      b_ss = (i % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        chk2("bounce_hold", state, 2'd2);
      end
    end
    b_ss = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk2("bounce_settle", state, 2'd2);
    end
    @(negedge clk);
    chk2("resume_run", state, 2'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk1("resume_tick", tick_sec, k == 7);
      if (k == 7) chk1("model_resume", m_tick, 1'b1);
    end

    // Clear and start/stop together, landing on a cycle that would tick.
    b_ss = 1'b0;
    repeat (12) @(negedge clk);
    b_ss = 1'b1; b_clr = 1'b1;
    repeat (8) @(negedge clk);
    chk2("clr_state", state, 2'd0);
    chk1("clr_pulse", clear_cnt, 1'b1);
    chk1("clr_no_tick", tick_sec, 1'b0);
    chk1("model_clr", m_clr, 1'b1);
    @(negedge clk);
    chk1("clr_one_cycle", clear_cnt, 1'b0);
    chk2("clr_stay_idle", state, 2'd0);
    b_ss = 1'b0; b_clr = 1'b0;

    // Reset mid-run with the prescaler at 6.
    repeat (10) @(negedge clk);
    b_ss = 1'b1;
    repeat (8) @(negedge clk);
    chk2("mid_run", state, 2'd1);
    b_ss = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk2("mid_rst_state", state, 2'd0);
    chk1("mid_rst_tick", tick_sec, 1'b0);
    chk1("mid_rst_running", running, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk1("post_rst_no_tick", tick_sec, 1'b0);
      chk2("post_rst_idle", state, 2'd0);
    end

    // Randomized button activity with occasional resets.
    for (int blk = 0; blk < 300; blk++) begin
      b_ss  = 1'($urandom_range(0, 1));
      b_clr = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 40) != 0);
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    rst = 1'b1; b_ss = 1'b0; b_clr = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
